usart_rx_deser: RTL and testbench

//  UART receive deserializer. Oversamples the async i_rx pin, recovers 8N1 frames (8E1/8O1 with parity option)
//  and presents byte + valid/error status to the USART RIB peripheral, which polls them as rx_vld/rx_err/rx_data.

---
 rtl/usart_rx_deser.sv | 200 ++++++++++++++++++++
 tb/tb_usart_rx_deser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/usart_rx_deser.sv
// ---------------------------------------------------------------------------
// usart_rx_deser
//   UART receive deserializer. The asynchronous rx pin is synchronised,
//   oversampled and decoded as 8N1 frames (8E1/8O1 when the parity option is
//   built in). The received byte and its status are held for the USART RIB
//   register block, which polls vld/err/ovr and pulses i_rx_ack on a read.
//
//   Build option: define USART_RX_PARITY_EN to add a parity bit after the
//   eight data bits (sense selected by PARITY_ODD). Undefined: plain 8N1.
//
// Handshake: o_rx_vld / o_rx_err are levels that stay up until the consumer
//   pulses i_rx_ack for one clock; a frame completing while either is still
//   up sets the sticky o_rx_ovr and overwrites data and flags.
//
// Ports
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_rx         serial line, asynchronous, idle high
//   i_rx_ack     1-clk pulse, consumer took the byte (clears vld/err/ovr)
//   o_rx_data    last received byte (LSB first on the line)
//   o_rx_vld     good frame held in o_rx_data
//   o_rx_err     last frame bad (framing, or parity when enabled)
//   o_rx_ovr     sticky overrun
//   o_rx_busy    receiver FSM not idle
//   o_dbg_state  current FSM state encoding, for observation
// ---------------------------------------------------------------------------
module usart_rx_deser #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    input  logic       i_rx_ack,
    output logic [7:0] o_rx_data,
    output logic       o_rx_vld,
    output logic       o_rx_err,
    output logic       o_rx_ovr,
    output logic       o_rx_busy,
    output logic [2:0] o_dbg_state
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);

    // Tick counter value during the tick on which each sample is taken.
    // The tick with counter value n is the (n+1)-th tick of the bit, so the
    // decision tick below is tick OVERSAMPLE/2 of the bit.
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 3);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MAX = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_WAITHI = 3'd5
    } state_t;

    state_t        state_q;
    logic          rx_s1_q;
    logic          rxs_q;
    logic          rxs_dly_q;
    logic [PW-1:0] presc_q;
    logic [TW-1:0] tick_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [1:0]    samp_q;
    logic          par_bad_q;
    logic [7:0]    data_q;
    logic          vld_q;
    logic          err_q;
    logic          ovr_q;

    logic tick;
    logic decide;
    logic maj;
    logic fall;
    logic par_exp;
    logic frame_done;
    logic frame_good;

    assign tick       = (presc_q == PW'(DIV - 1));
    assign decide     = tick && (tick_cnt_q == T_DEC);
    // Majority of the two stored samples and the live synced line.
    assign maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    assign fall       = rxs_dly_q & ~rxs_q;
    assign par_exp    = (^shift_q) ^ 1'(PARITY_ODD);
    assign frame_done = (state_q == S_STOP) && decide;
    assign frame_good = maj && !par_bad_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            rx_s1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_dly_q  <= 1'b1;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            samp_q     <= '0;
            par_bad_q  <= 1'b0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            rx_s1_q   <= i_rx;
            rxs_q     <= rx_s1_q;
            rxs_dly_q <= rxs_q;

            // Counters are held at zero while idle, so bit timing starts
            // from the cycle after the falling edge was detected.
            if (state_q == S_IDLE) begin
                presc_q    <= '0;
                tick_cnt_q <= '0;
            end else if (tick) begin
                presc_q    <= '0;
                tick_cnt_q <= (tick_cnt_q == T_MAX) ? '0 : tick_cnt_q + 1'b1;
                if (tick_cnt_q == T_S0) samp_q[0] <= rxs_q;
                if (tick_cnt_q == T_S1) samp_q[1] <= rxs_q;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (fall) state_q <= S_START;
                end
                S_START: begin
                    if (decide) begin
                        if (maj) begin
                            state_q <= S_IDLE;      // glitch, not a start bit
                        end else begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                            par_bad_q <= 1'b0;
                        end
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shift_q   <= {maj, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef USART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end
                    end
                end
                S_PARITY: begin
                    if (decide) begin
                        par_bad_q <= (maj != par_exp);
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Leave at mid stop bit so the next start edge is caught
                    // even if the transmitter runs slightly fast.
                    if (decide) state_q <= maj ? S_IDLE : S_WAITHI;
                end
                S_WAITHI: begin
                    if (rxs_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // A completing frame wins over a simultaneous ack; the ack then
            // only suppresses the overrun since the old byte was consumed.
            if (frame_done) begin
                data_q <= shift_q;
                vld_q  <= frame_good;
                err_q  <= !frame_good;
                ovr_q  <= i_rx_ack ? 1'b0 : (ovr_q | vld_q | err_q);
            end else if (i_rx_ack) begin
                vld_q <= 1'b0;
                err_q <= 1'b0;
                ovr_q <= 1'b0;
            end
        end
    end

    assign o_rx_data   = data_q;
    assign o_rx_vld    = vld_q;
    assign o_rx_err    = err_q;
    assign o_rx_ovr    = ovr_q;
    assign o_rx_busy   = (state_q != S_IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_usart_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_usart_rx_deser
//   Directed bench for usart_rx_deser at 16 clocks per bit (DIV = 1).
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// ---------------------------------------------------------------------------
module tb_usart_rx_deser;

    localparam int BIT_CLK = 16;
`ifdef USART_RX_PARITY_EN
    localparam int LAT = 171;   // fall of start bit to vld, 11-bit frame
`else
    localparam int LAT = 155;   // fall of start bit to vld, 10-bit frame
`endif

    logic       clk;
    logic       rst;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_err;
    logic       rx_ovr;
    logic       rx_busy;
    logic [2:0] dbg_state;

    int n_cmp;
    int n_bad;
    int lat;

    usart_rx_deser #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .OVERSAMPLE(16),
        .PARITY_ODD(0)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx       (rx),
        .i_rx_ack   (rx_ack),
        .o_rx_data  (rx_data),
        .o_rx_vld   (rx_vld),
        .o_rx_err   (rx_err),
        .o_rx_ovr   (rx_ovr),
        .o_rx_busy  (rx_busy),
        .o_dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // checking
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic drive_bit(input logic b);
        rx = b;
        step(BIT_CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef USART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx) rx = 1'b1;   // parity bit not on the line
`endif
        drive_bit(stop);
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
    endtask

    // Counts rising edges from now until vld is seen, bounded.
    task automatic wait_vld(output int n);
        n = 0;
        while (!rx_vld && n < 400) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        rx     = 1'b1;
        rx_ack = 1'b0;
        step(3);
        rst = 1'b0;
        step(3);

        check("reset_data", rx_data, 8'h00);
        check("reset_vld",  rx_vld,  1'b0);
        check("reset_err",  rx_err,  1'b0);
        check("reset_ovr",  rx_ovr,  1'b0);
        check("reset_busy", rx_busy, 1'b0);

        // good frame 0xA5 with latency measurement
        fork
            send_frame(8'hA5, ^8'hA5, 1'b1);
            wait_vld(lat);
        join
        check("a5_latency", lat, LAT);
        check("a5_data", rx_data, 8'hA5);
        check("a5_vld",  rx_vld,  1'b1);
        check("a5_err",  rx_err,  1'b0);
        check("a5_ovr",  rx_ovr,  1'b0);
        step(4);
        pulse_ack();
        check("a5_ack_vld", rx_vld, 1'b0);
        check("a5_ack_data_held", rx_data, 8'hA5);
        pulse_ack();
        check("idle_ack_ovr", rx_ovr, 1'b0);
        check("idle_ack_err", rx_err, 1'b0);

        // 4-clock glitch is rejected
        rx = 1'b0;
        step(4);
        check("glitch_busy_early", rx_busy, 1'b1);
        rx = 1'b1;
        step(12);
        check("glitch_busy_late", rx_busy, 1'b0);
        check("glitch_vld", rx_vld, 1'b0);
        check("glitch_err", rx_err, 1'b0);
        step(10);

        // framing error, then line held low
        send_frame(8'h3C, ^8'h3C, 1'b0);
        rx = 1'b0;
        step(40);
        check("ferr_err",  rx_err,  1'b1);
        check("ferr_vld",  rx_vld,  1'b0);
        check("ferr_data", rx_data, 8'h3C);
        check("ferr_busy_low", rx_busy, 1'b1);
        rx = 1'b1;
        step(4);
        check("ferr_busy_high", rx_busy, 1'b0);
        pulse_ack();
        check("ferr_ack_err", rx_err, 1'b0);
        step(10);

        // overrun: two frames without ack
        send_frame(8'h11, ^8'h11, 1'b1);
        send_frame(8'h22, ^8'h22, 1'b1);
        step(4);
        check("ovr_vld",  rx_vld,  1'b1);
        check("ovr_data", rx_data, 8'h22);
        check("ovr_ovr",  rx_ovr,  1'b1);
        check("ovr_err",  rx_err,  1'b0);
        pulse_ack();
        check("ovr_ack_vld", rx_vld, 1'b0);
        check("ovr_ack_ovr", rx_ovr, 1'b0);
        step(10);

        // leave a byte pending, then reset in bit 4 of 0x55
        send_frame(8'h99, ^8'h99, 1'b1);
        step(4);
        check("pre_rst_vld", rx_vld, 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(((8'h55 >> i) & 8'h01) != 0);
        rx = 1'b1;
        step(8);
        check("mid_busy", rx_busy, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("rst_data", rx_data, 8'h00);
        check("rst_vld",  rx_vld,  1'b0);
        check("rst_err",  rx_err,  1'b0);
        check("rst_ovr",  rx_ovr,  1'b0);
        check("rst_busy", rx_busy, 1'b0);
        step(20);
        send_frame(8'h66, ^8'h66, 1'b1);
        step(4);
        check("post_rst_vld",  rx_vld,  1'b1);
        check("post_rst_data", rx_data, 8'h66);
        check("post_rst_err",  rx_err,  1'b0);
        check("post_rst_ovr",  rx_ovr,  1'b0);
        pulse_ack();
        step(10);

`ifdef USART_RX_PARITY_EN
        // even parity: 0x07 has three ones, parity bit must be 1
        send_frame(8'h07, 1'b1, 1'b1);
        step(4);
        check("par_good_vld", rx_vld, 1'b1);
        check("par_good_err", rx_err, 1'b0);
        pulse_ack();
        step(10);
        send_frame(8'h07, 1'b0, 1'b1);
        step(4);
        check("par_bad_vld",  rx_vld,  1'b0);
        check("par_bad_err",  rx_err,  1'b1);
        check("par_bad_data", rx_data, 8'h07);
        pulse_ack();
        step(10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
